// File: rtl/axis_pixels_shift_sched_if.sv
// Handshake bundle for the per-layer pixel sequencer: layer config, upstream pixels, downstream beats.
// The design binds to the slave modport; a driver or the bench binds to master.
interface axis_pixels_shift_sched_if #(
    parameter int unsigned IM_SHIFT_REGS = 8,
    parameter int unsigned WORD_WIDTH    = 8,
    parameter int unsigned BITS_IM_SHIFT = 4,
    parameter int unsigned BITS_COLS     = 10,
    parameter int unsigned BITS_BLOCKS   = 10
);
    logic                                cfg_valid;
    logic                                cfg_ready;
    logic [BITS_IM_SHIFT-1:0]            cfg_shift;
    logic                                cfg_is_max;
    logic                                cfg_ones;
    logic [BITS_COLS-1:0]                cfg_cols;
    logic [BITS_BLOCKS-1:0]              cfg_blocks;

    logic                                u_valid;
    logic                                u_ready;
    logic [IM_SHIFT_REGS*WORD_WIDTH-1:0] u_data;

    logic                                m_valid;
    logic                                m_ready;
    logic [IM_SHIFT_REGS*WORD_WIDTH-1:0] m_data;
    logic [BITS_IM_SHIFT-1:0]            m_shift;
    logic                                m_ones;
    logic                                m_is_max;
    logic                                m_last_col;
    logic                                m_last;

    modport master (
        output cfg_valid, cfg_shift, cfg_is_max, cfg_ones, cfg_cols, cfg_blocks,
        input  cfg_ready,
        output u_valid, u_data,
        input  u_ready,
        input  m_valid, m_data, m_shift, m_ones, m_is_max, m_last_col, m_last,
        output m_ready
    );

    modport slave (
        input  cfg_valid, cfg_shift, cfg_is_max, cfg_ones, cfg_cols, cfg_blocks,
        output cfg_ready,
        input  u_valid, u_data,
        output u_ready,
        output m_valid, m_data, m_shift, m_ones, m_is_max, m_last_col, m_last,
        input  m_ready
    );
endinterface

// File: rtl/axis_pixels_shift_sched.sv
// Per-layer sequencer ahead of the pixel shift stage: latches a layer config, then forwards the
// pixel stream block by block, optionally prefixing each block with an all-ones beat.
module axis_pixels_shift_sched #(
    parameter int unsigned IM_SHIFT_REGS = 8,
    parameter int unsigned WORD_WIDTH    = 8,
    parameter int unsigned BITS_IM_SHIFT = 4,
    parameter int unsigned BITS_COLS     = 10,
    parameter int unsigned BITS_BLOCKS   = 10
) (
    input logic                          aclk,
    input logic                          aresetn,
    axis_pixels_shift_sched_if.slave     pix_io
);

    typedef enum logic [1:0] {StIdle, StOnes, StRun} state_e;

    state_e                   state_q, state_d;
    logic [BITS_COLS-1:0]     col_q, col_d;
    logic [BITS_BLOCKS-1:0]   block_q, block_d;
    logic [BITS_IM_SHIFT-1:0] shift_q, shift_d;
    logic                     is_max_q, is_max_d;
    logic                     ones_q, ones_d;
    logic [BITS_COLS-1:0]     cols_q, cols_d;
    logic [BITS_BLOCKS-1:0]   blocks_q, blocks_d;

    logic [IM_SHIFT_REGS*WORD_WIDTH-1:0] ones_data;
    logic                                last_col;
    logic                                last_block;

    always_comb begin
        ones_data = '0;
        for (int i = 0; i < int'(IM_SHIFT_REGS); i++) begin
            ones_data[i*WORD_WIDTH +: WORD_WIDTH] = WORD_WIDTH'(1);
        end
    end

    assign last_col   = (col_q == cols_q);
    assign last_block = (block_q == blocks_q);

    assign pix_io.m_shift  = shift_q;
    assign pix_io.m_is_max = is_max_q;

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        block_d  = block_q;
        shift_d  = shift_q;
        is_max_d = is_max_q;
        ones_d   = ones_q;
        cols_d   = cols_q;
        blocks_d = blocks_q;

        pix_io.cfg_ready  = 1'b0;
        pix_io.u_ready    = 1'b0;
        pix_io.m_valid    = 1'b0;
        pix_io.m_data     = '0;
        pix_io.m_ones     = 1'b0;
        pix_io.m_last_col = 1'b0;
        pix_io.m_last     = 1'b0;

        unique case (state_q)
            StIdle: begin
                pix_io.cfg_ready = 1'b1;
                if (pix_io.cfg_valid) begin
                    shift_d  = pix_io.cfg_shift;
                    is_max_d = pix_io.cfg_is_max;
                    ones_d   = pix_io.cfg_ones;
                    cols_d   = pix_io.cfg_cols;
                    blocks_d = pix_io.cfg_blocks;
                    col_d    = '0;
                    block_d  = '0;
                    state_d  = pix_io.cfg_ones ? StOnes : StRun;
                end
            end
            StOnes: begin
                pix_io.m_valid = 1'b1;
                pix_io.m_ones  = 1'b1;
                pix_io.m_data  = ones_data;
                if (pix_io.m_ready) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // Combinational pass-through: no register between upstream and the shift stage.
                pix_io.m_valid    = pix_io.u_valid;
                pix_io.u_ready    = pix_io.m_ready;
                pix_io.m_data     = pix_io.u_data;
                pix_io.m_last_col = last_col;
                pix_io.m_last     = last_col & last_block;
                if (pix_io.u_valid && pix_io.m_ready) begin
                    if (!last_col) begin
                        col_d = col_q + BITS_COLS'(1);
                    end else begin
                        col_d = '0;
                        if (last_block) begin
                            state_d = StIdle;
                        end else begin
                            block_d = block_q + BITS_BLOCKS'(1);
                            state_d = ones_q ? StOnes : StRun;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= StIdle;
            col_q    <= '0;
            block_q  <= '0;
            shift_q  <= '0;
            is_max_q <= 1'b0;
            ones_q   <= 1'b0;
            cols_q   <= '0;
            blocks_q <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            block_q  <= block_d;
            shift_q  <= shift_d;
            is_max_q <= is_max_d;
            ones_q   <= ones_d;
            cols_q   <= cols_d;
            blocks_q <= blocks_d;
        end
    end

endmodule

// File: tb/tb_axis_pixels_shift_sched.sv
// Directed bench for axis_pixels_shift_sched: reset, pass-through, ones beats, backpressure,
// single-pixel layer, mid-layer reset and back-to-back configs.
module tb_axis_pixels_shift_sched;

    localparam int unsigned IM_SHIFT_REGS = 8;
    localparam int unsigned WORD_WIDTH    = 8;
    localparam int unsigned BITS_IM_SHIFT = 4;
    localparam int unsigned BITS_COLS     = 10;
    localparam int unsigned BITS_BLOCKS   = 10;
    localparam logic [63:0] ONES_DATA     = 64'h0101_0101_0101_0101;

    typedef struct packed {
        logic [63:0] data;
        logic        ones;
        logic        last_col;
        logic        last;
        logic [3:0]  shift;
        logic        is_max;
    } beat_t;

    logic aclk = 1'b0;
    logic aresetn;

    axis_pixels_shift_sched_if #(
        .IM_SHIFT_REGS(IM_SHIFT_REGS), .WORD_WIDTH(WORD_WIDTH), .BITS_IM_SHIFT(BITS_IM_SHIFT),
        .BITS_COLS(BITS_COLS), .BITS_BLOCKS(BITS_BLOCKS)
    ) pix_if ();

    axis_pixels_shift_sched #(
        .IM_SHIFT_REGS(IM_SHIFT_REGS), .WORD_WIDTH(WORD_WIDTH), .BITS_IM_SHIFT(BITS_IM_SHIFT),
        .BITS_COLS(BITS_COLS), .BITS_BLOCKS(BITS_BLOCKS)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .pix_io  (pix_if)
    );

    always #5 aclk = ~aclk;

    int    errors = 0;
    int    checks = 0;
    beat_t got_q[$];
    beat_t exp_q[$];
    beat_t layer_a_q[$];
    int    first_valid;
    logic  ready_at_last;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pix(input int idx);
        return 64'hC0DE_0000_0000_0000 | 64'(idx);
    endfunction

    // Expected beat sequence of a whole layer, built block by block.
    task automatic build_exp(input logic [3:0] shift, input logic is_max, input logic ones,
                             input int cols, input int blocks);
        int k = 0;
        beat_t b;
        exp_q.delete();
        for (int blk = 0; blk <= blocks; blk++) begin
            if (ones) begin
                b = '{data: ONES_DATA, ones: 1'b1, last_col: 1'b0, last: 1'b0,
                      shift: shift, is_max: is_max};
                exp_q.push_back(b);
            end
            for (int c = 0; c <= cols; c++) begin
                b = '{data: pix(k), ones: 1'b0, last_col: (c == cols),
                      last: (c == cols) && (blk == blocks), shift: shift, is_max: is_max};
                exp_q.push_back(b);
                k++;
            end
        end
    endtask

    task automatic compare_layer(input string tag);
        int n;
        check({tag, "_count"}, 80'(got_q.size()), 80'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_beat%0d", tag, i), 80'(got_q[i]), 80'(exp_q[i]));
        end
    endtask

    task automatic send_cfg(input logic [3:0] shift, input logic is_max, input logic ones,
                            input int cols, input int blocks);
        @(negedge aclk);
        pix_if.cfg_valid  = 1'b1;
        pix_if.cfg_shift  = shift;
        pix_if.cfg_is_max = is_max;
        pix_if.cfg_ones   = ones;
        pix_if.cfg_cols   = BITS_COLS'(cols);
        pix_if.cfg_blocks = BITS_BLOCKS'(blocks);
        #1;
        check("cfg_ready_idle", 80'(pix_if.cfg_ready), 80'(1));
        check("no_valid_in_cfg_cycle", 80'(pix_if.m_valid), 80'(0));
        @(posedge aclk);
        #1 pix_if.cfg_valid = 1'b0;
    endtask

    // Drives upstream/downstream with pu/pm percent probabilities and records accepted beats.
    task automatic capture(input int max_beats, input int pu, input int pm, input int budget);
        int          up_idx = 0;
        int          cyc = 0;
        bit          done = 0;
        bit          held = 0;
        logic [65:0] held_vec = '0;
        beat_t       b;
        got_q.delete();
        first_valid = -1;
        while (!done) begin
            @(negedge aclk);
            pix_if.u_valid = ($urandom_range(99) < pu);
            pix_if.m_ready = ($urandom_range(99) < pm);
            pix_if.u_data  = pix(up_idx);
            #1;
            if (first_valid < 0 && pix_if.m_valid) first_valid = cyc;
            if (held) check("ones_stable", 80'({pix_if.m_valid, pix_if.m_ones, pix_if.m_data}),
                            80'(held_vec));
            if (pix_if.m_ones) check("u_ready_low_in_ones", 80'(pix_if.u_ready), 80'(0));
            held     = pix_if.m_valid && pix_if.m_ones && !pix_if.m_ready;
            held_vec = {pix_if.m_valid, pix_if.m_ones, pix_if.m_data};
            if (pix_if.m_valid && pix_if.m_ready) begin
                b = '{data: pix_if.m_data, ones: pix_if.m_ones, last_col: pix_if.m_last_col,
                      last: pix_if.m_last, shift: pix_if.m_shift, is_max: pix_if.m_is_max};
                got_q.push_back(b);
                ready_at_last = pix_if.cfg_ready;
                if (pix_if.m_last || got_q.size() == max_beats) done = 1;
            end
            if (pix_if.u_valid && pix_if.u_ready) up_idx++;
            cyc++;
            if (!done && cyc >= budget) begin
                checks++;
                errors++;
                $error("FAIL capture_timeout observed=%0d beats expected=layer end", got_q.size());
                done = 1;
            end
        end
    endtask

    task automatic check_idle_next(input string tag);
        @(negedge aclk);
        #1;
        check({tag, "_cfg_ready"}, 80'(pix_if.cfg_ready), 80'(1));
        check({tag, "_m_valid"}, 80'(pix_if.m_valid), 80'(0));
    endtask

    initial begin
        aresetn           = 1'b0;
        pix_if.cfg_valid  = 1'b0;
        pix_if.cfg_shift  = '0;
        pix_if.cfg_is_max = 1'b0;
        pix_if.cfg_ones   = 1'b0;
        pix_if.cfg_cols   = '0;
        pix_if.cfg_blocks = '0;
        pix_if.u_valid    = 1'b0;
        pix_if.u_data     = '0;
        pix_if.m_ready    = 1'b0;
        repeat (2) @(negedge aclk);
        #1;
        check("rst_state", 80'({pix_if.cfg_ready, pix_if.m_valid, pix_if.u_ready, pix_if.m_shift,
                                pix_if.m_is_max, pix_if.m_ones, pix_if.m_last_col, pix_if.m_last}),
              80'({1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0}));
        @(posedge aclk);
        #2 aresetn = 1'b1;

        // Plain pass-through, two blocks of four.
        send_cfg(4'd2, 1'b0, 1'b0, 3, 1);
        capture(100, 100, 100, 50);
        check("t1_latency", 80'(first_valid), 80'(0));
        check("t1_beat4_last_col", 80'(got_q[3].last_col), 80'(1));
        check("t1_beat4_not_last", 80'(got_q[3].last), 80'(0));
        check("t1_beat8_last", 80'({got_q[7].last_col, got_q[7].last}), 80'(2'b11));
        check("t1_busy_at_last", 80'(ready_at_last), 80'(0));
        build_exp(4'd2, 1'b0, 1'b0, 3, 1);
        compare_layer("t1");
        check_idle_next("t1_end");

        // Same layer with a ones beat ahead of each block.
        send_cfg(4'd2, 1'b0, 1'b1, 3, 1);
        capture(100, 100, 100, 50);
        check("t2_beat1_ones", 80'({got_q[0].ones, got_q[0].data}), 80'({1'b1, ONES_DATA}));
        check("t2_beat6_ones", 80'({got_q[5].ones, got_q[5].data}), 80'({1'b1, ONES_DATA}));
        build_exp(4'd2, 1'b0, 1'b1, 3, 1);
        compare_layer("t2");
        check_idle_next("t2_end");

        // Random backpressure on both sides.
        send_cfg(4'd7, 1'b1, 1'b1, 15, 3);
        capture(1000, 50, 50, 3000);
        build_exp(4'd7, 1'b1, 1'b1, 15, 3);
        compare_layer("t3");
        check_idle_next("t3_end");

        // Single-pixel layer with a ones beat.
        send_cfg(4'd1, 1'b0, 1'b1, 0, 0);
        capture(100, 100, 100, 20);
        build_exp(4'd1, 1'b0, 1'b1, 0, 0);
        compare_layer("t4");
        check_idle_next("t4_end");

        // Reset in the middle of a layer, then a fresh layer must start at col 0.
        send_cfg(4'd9, 1'b1, 1'b0, 7, 0);
        capture(5, 100, 100, 20);
        check("t5_pre_rst_beats", 80'(got_q.size()), 80'(5));
        @(negedge aclk);
        pix_if.u_valid = 1'b0;
        pix_if.m_ready = 1'b0;
        aresetn        = 1'b0;
        #1;
        check("t5_rst_outputs", 80'({pix_if.m_valid, pix_if.cfg_ready, pix_if.m_shift,
                                     pix_if.m_is_max, pix_if.u_ready}),
              80'({1'b0, 1'b1, 4'd0, 1'b0, 1'b0}));
        @(posedge aclk);
        #2 aresetn = 1'b1;
        send_cfg(4'd6, 1'b0, 1'b0, 7, 0);
        capture(100, 100, 100, 30);
        build_exp(4'd6, 1'b0, 1'b0, 7, 0);
        compare_layer("t5");
        check_idle_next("t5_end");

        // Back-to-back configs with cfg_valid held high throughout.
        @(negedge aclk);
        pix_if.cfg_valid  = 1'b1;
        pix_if.cfg_shift  = 4'd3;
        pix_if.cfg_is_max = 1'b0;
        pix_if.cfg_ones   = 1'b0;
        pix_if.cfg_cols   = BITS_COLS'(1);
        pix_if.cfg_blocks = BITS_BLOCKS'(0);
        @(posedge aclk);
        #1;
        pix_if.cfg_shift  = 4'd5;
        pix_if.cfg_is_max = 1'b1;
        capture(100, 100, 100, 20);
        layer_a_q = got_q;
        build_exp(4'd3, 1'b0, 1'b0, 1, 0);
        compare_layer("t6a");
        check_idle_next("t6_gap");
        @(posedge aclk);
        #1 pix_if.cfg_valid = 1'b0;
        capture(100, 100, 100, 20);
        check("t6b_no_extra_gap", 80'(first_valid), 80'(0));
        check("t6b_first_tags", 80'({got_q[0].is_max, got_q[0].shift}), 80'({1'b1, 4'd5}));
        check("t6a_tags", 80'({layer_a_q[0].is_max, layer_a_q[0].shift}), 80'({1'b0, 4'd3}));
        build_exp(4'd5, 1'b1, 1'b0, 1, 0);
        compare_layer("t6b");
        check_idle_next("t6_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_pixels_shift_sched.md
# axis_pixels_shift_sched

Per-layer sequencer placed directly upstream of the pixel shift-register stage.
- Accepts one layer configuration at a time, then forwards the upstream pixel stream block by block.
- Inserts an optional "ones" beat at the start of every block.
- Tags every beat with the layer's shift count, max-pool flag and column/block boundary flags.
- Returns to idle after the last beat of the layer, ready for the next configuration.

## Interface
Parameters:
- IM_SHIFT_REGS, 8, words per pixel beat
- WORD_WIDTH, 8, bits per word
- BITS_IM_SHIFT, 4, width of shift count
- BITS_COLS, 10, width of column count
- BITS_BLOCKS, 10, width of block count

Ports:
- aclk  in  1  clock; one clock, all logic rising-edge
- aresetn  in  1  reset, asynchronous assert, active-low
- cfg_valid  in  1  configuration valid
- cfg_ready  out  1  configuration accepted when high with cfg_valid
- cfg_shift  in  BITS_IM_SHIFT  shift count for the layer
- cfg_is_max  in  1  layer uses max-pool copies
- cfg_ones  in  1  insert a ones beat before each block
- cfg_cols  in  BITS_COLS  pixel beats per block minus 1
- cfg_blocks  in  BITS_BLOCKS  blocks per layer minus 1
- u_valid / u_ready  in / out  1  upstream pixel handshake
- u_data  in  IM_SHIFT_REGS*WORD_WIDTH  upstream pixel words
- m_valid / m_ready  out / in  1  downstream handshake to the shift stage
- m_data  out  IM_SHIFT_REGS*WORD_WIDTH  beat data
- m_shift  out  BITS_IM_SHIFT  latched cfg_shift
- m_ones  out  1  current beat is a ones beat
- m_is_max  out  1  latched cfg_is_max
- m_last_col  out  1  last pixel beat of the block
- m_last  out  1  last pixel beat of the layer

## Operation
States are IDLE, ONES and RUN.

IDLE:
- cfg_ready=1, m_valid=0, u_ready=0.
- On cfg_valid&cfg_ready, latch all cfg_* fields and clear col/block counters.
- Go to ONES if cfg_ones=1, else RUN.

ONES:
- m_valid=1, m_ones=1, u_ready=0.
- m_data: every word = 1 (LSB set, other bits 0).
- m_last_col=0, m_last=0.
- On m_ready, go to RUN.

RUN:
- m_valid=u_valid, u_ready=m_ready, m_data=u_data, m_ones=0.
- The handshake fires when u_valid&m_ready.
- m_last_col = (col==cfg_cols); m_last = m_last_col & (block==cfg_blocks).

On each RUN handshake:
- If col<cfg_cols: col+1.
- Otherwise col=0, and then:
  - if block==cfg_blocks: go to IDLE;
  - otherwise block+1, and go to ONES if the latched ones flag is set, else stay in RUN.

Outputs and widths:
- m_shift and m_is_max are constant for the whole layer; they hold their last value while in IDLE.
- Counters are unsigned. A count field of 0 means one item.
- Counter widths equal the cfg field widths; there is no wrap-around inside a layer.

Stalls and reset:
- The block holds all state while m_ready=0. A ones beat stays presented, unchanged, until it is accepted.
- Reset mid-layer: the layer is abandoned, the state returns to IDLE, and the latched config is cleared to 0.

## Timing
Reset values:
- State IDLE, counters 0, latched config 0.
- So after reset: cfg_ready=1, m_valid=0, u_ready=0, m_shift=0, m_is_max=0, m_ones=0, m_last_col=0, m_last=0.

Latency:
- Config handshake to first m_valid: 1 cycle. m_valid is never high in the handshake cycle itself.
- RUN has zero-latency combinational pass-through. Data, valid and ready must not be registered in RUN.
- m_last-beat handshake to cfg_ready=1: 1 cycle. This gives exactly one bubble between layers.

Ordering and handshake rules:
- A ones beat occupies one accepted handshake; block N's ones beat always precedes block N's first pixel.
- u_ready is never high outside RUN. No upstream beat is consumed during IDLE or ONES.
- cfg_valid held high while busy is ignored until IDLE. A config presented in the cycle the layer ends is accepted one cycle later.

## Test plan
- Config shift=2, ones=0, cols=3, blocks=1, 8 upstream beats, m_ready=1 → 8 pass-through beats; m_last_col on beats 4 and 8, m_last only on beat 8; cfg_ready high 1 cycle after beat 8.
- Same config with ones=1 → 10 beats: ones beat (all words 1, m_ones=1), 4 pixels, ones beat, 4 pixels; u_ready low during both ones beats.
- Random m_ready/u_valid backpressure (≈50%) over cols=15, blocks=3 → output sequence identical to the no-stall run; no beat dropped or duplicated; ones beats stable while stalled.
- cols=0, blocks=0, ones=1 → exactly 2 beats (ones, then one pixel with m_last_col=m_last=1), then IDLE.
- Assert aresetn low after 5 beats of cols=7 layer → within the reset cycle m_valid=0, cfg_ready=1, m_shift=0; a new config is accepted and starts with col=0.
- Back-to-back configs with cfg_valid held high (is_max 0 then 1, shift 3 then 5) → second layer's first beat carries m_is_max=1, m_shift=5; exactly one idle cycle between layers.
